// File: rtl/reg_file_sb.sv
// Parametrised 2-read/1-write register file with same-cycle write bypass,
// per-entry busy scoreboard and a hardware clear sweep of the storage array.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd1_busy,
  output logic              rd2_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_wa,
  input  logic              flush,
  input  logic              clr,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLR, ST_RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   rf [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic                wr_ok;
  logic                iss_ok;
  logic                hit1;
  logic                hit2;
  logic                zero1;
  logic                zero2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLR;
    else     state <= state_nxt;
  end

  // Next-state logic: the sweep ends on the cycle that zeroes the last entry
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_CLR:  if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:  if (clr) state_nxt = ST_CLR;
      default: state_nxt = ST_CLR;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state == ST_RUN);
  end

  assign wr_ok  = ready && we && !((ZERO_REG != 0) && (wa == '0));
  assign iss_ok = ready && issue_valid && !flush && !((ZERO_REG != 0) && (issue_wa == '0));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  clr_ptr <= '0;
    else if (state == ST_CLR) clr_ptr <= clr_ptr + ADDR_W'(1);
    else                      clr_ptr <= '0;
  end

  // NOTE: the array has no reset; the sweep is the only initialisation, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (!ready)     rf[clr_ptr] <= '0;
    else if (wr_ok) rf[wa]      <= wd;
  end

  // Issue set is written after writeback clear, so set wins on the same entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (!ready || clr || flush) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[wa]       <= 1'b0;
      if (iss_ok) busy[issue_wa] <= 1'b1;
    end
  end

  assign hit1  = (BYPASS != 0) && wr_ok && (wa == ra1);
  assign hit2  = (BYPASS != 0) && wr_ok && (wa == ra2);
  assign zero1 = (ZERO_REG != 0) && (ra1 == '0);
  assign zero2 = (ZERO_REG != 0) && (ra2 == '0);

  assign rd1 = (!ready || zero1) ? '0 : (hit1 ? wd : rf[ra1]);
  assign rd2 = (!ready || zero2) ? '0 : (hit2 ? wd : rf[ra2]);

  assign rd1_busy = ready && !zero1 && busy[ra1] && !hit1;
  assign rd2_busy = ready && !zero2 && busy[ra2] && !hit2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: table-driven RUN vectors plus hand-written
// reset, clear-sweep and asynchronous-reset sequences, checked through a scoreboard queue.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa, issue_wa;
  logic [DW-1:0] wd;
  logic          we, issue_valid, flush, clr;
  logic [DW-1:0] rd1, rd2, rd1_nb, rd2_nb;
  logic          rd1_busy, rd2_busy, rd1_busy_nb, rd2_busy_nb;
  logic          ready, ready_nb;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .we(we), .wa(wa), .wd(wd),
    .issue_valid(issue_valid), .issue_wa(issue_wa), .flush(flush), .clr(clr),
    .ready(ready)
  );

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .rd1_busy(rd1_busy_nb), .rd2_busy(rd2_busy_nb), .we(we), .wa(wa), .wd(wd),
    .issue_valid(issue_valid), .issue_wa(issue_wa), .flush(flush), .clr(clr),
    .ready(ready_nb)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          iv;
    logic [AW-1:0] iwa;
    logic          fl;
    logic          cl;
    logic [DW-1:0] e_rd1;
    logic [DW-1:0] e_rd2;
    logic          e_b1;
    logic          e_b2;
    logic          e_rdy;
    logic [DW-1:0] e_nb1;
  } vec_t;

  vec_t sb [$];
  vec_t vt [19];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(
    input logic we_i, input logic [AW-1:0] wa_i, input logic [DW-1:0] wd_i,
    input logic [AW-1:0] ra1_i, input logic [AW-1:0] ra2_i,
    input logic iv_i, input logic [AW-1:0] iwa_i, input logic fl_i, input logic cl_i,
    input logic [DW-1:0] rd1_e, input logic [DW-1:0] rd2_e,
    input logic b1_e, input logic b2_e, input logic rdy_e, input logic [DW-1:0] nb1_e);
    vec_t v;
    v.we = we_i;   v.wa = wa_i;   v.wd = wd_i;   v.ra1 = ra1_i; v.ra2 = ra2_i;
    v.iv = iv_i;   v.iwa = iwa_i; v.fl = fl_i;   v.cl = cl_i;
    v.e_rd1 = rd1_e; v.e_rd2 = rd2_e; v.e_b1 = b1_e; v.e_b2 = b2_e;
    v.e_rdy = rdy_e; v.e_nb1 = nb1_e;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, compare at +1, then ride through the rising edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    we = v.we; wa = v.wa; wd = v.wd; ra1 = v.ra1; ra2 = v.ra2;
    issue_valid = v.iv; issue_wa = v.iwa; flush = v.fl; clr = v.cl;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    check({tag, " rd1"},      rd1,      e.e_rd1);
    check({tag, " rd2"},      rd2,      e.e_rd2);
    check({tag, " rd1_busy"}, DW'(rd1_busy), DW'(e.e_b1));
    check({tag, " rd2_busy"}, DW'(rd2_busy), DW'(e.e_b2));
    check({tag, " ready"},    DW'(ready),    DW'(e.e_rdy));
    check({tag, " rd1_nb"},   rd1_nb,   e.e_nb1);
    @(negedge clk);
  endtask

  // Sweep cycles: the given stimulus must be ignored and all outputs held at 0.
  task automatic sweep(input int n, input vec_t stim, input string tag);
    vec_t v;
    v = stim;
    v.e_rd1 = '0; v.e_rd2 = '0; v.e_b1 = 1'b0; v.e_b2 = 1'b0;
    v.e_rdy = 1'b0; v.e_nb1 = '0;
    for (int i = 0; i < n; i++) step(v, $sformatf("%s%0d", tag, i));
  endtask

  initial begin
    vec_t idle;
    vec_t busy_stim;
    idle      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    busy_stim = mk(1, 12, 32'hFFFF_FFFF, 12, 13, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0);

    //        we wa wd            ra1 ra2 iv iwa fl cl  rd1           rd2           b1 b2 rdy nb1
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 5, 6, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 1, 32'h0);
    vt[1]  = mk(0, 0, 32'h0,        5, 5, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF);
    vt[2]  = mk(1, 0, 32'h1234,     0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0);
    vt[3]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0);
    vt[4]  = mk(0, 0, 32'h0,        7, 7, 1, 7, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0);
    vt[5]  = mk(0, 0, 32'h0,        7, 7, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 1, 32'h0);
    vt[6]  = mk(1, 7, 32'hAAAA5555, 7, 7, 1, 7, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 0, 0, 1, 32'h0);
    vt[7]  = mk(0, 0, 32'h0,        7, 7, 0, 0, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 1, 1, 1, 32'hAAAA5555);
    vt[8]  = mk(1, 7, 32'h11112222, 7, 5, 0, 0, 0, 0, 32'h11112222, 32'hDEADBEEF, 0, 0, 1, 32'hAAAA5555);
    vt[9]  = mk(0, 0, 32'h0,        7, 7, 0, 0, 0, 0, 32'h11112222, 32'h11112222, 0, 0, 1, 32'h11112222);
    vt[10] = mk(0, 0, 32'h0,        3, 4, 1, 3, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0);
    vt[11] = mk(0, 0, 32'h0,        3, 4, 1, 4, 0, 0, 32'h0,        32'h0,        1, 0, 1, 32'h0);
    vt[12] = mk(0, 0, 32'h0,        3, 4, 1, 9, 0, 0, 32'h0,        32'h0,        1, 1, 1, 32'h0);
    vt[13] = mk(0, 0, 32'h0,        9, 10, 1, 10, 1, 0, 32'h0,      32'h0,        1, 0, 1, 32'h0);
    vt[14] = mk(0, 0, 32'h0,        3, 9, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0);
    vt[15] = mk(0, 0, 32'h0,        4, 10, 0, 0, 0, 0, 32'h0,       32'h0,        0, 0, 1, 32'h0);
    vt[16] = mk(1, 12, 32'hFFFFFFFF, 12, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,      0, 0, 1, 32'h0);
    vt[17] = mk(0, 0, 32'h0,        12, 13, 1, 13, 0, 0, 32'hFFFFFFFF, 32'h0,     0, 0, 1, 32'hFFFFFFFF);
    vt[18] = mk(1, 14, 32'h12345678, 12, 13, 0, 0, 0, 1, 32'hFFFFFFFF, 32'h0,     0, 1, 1, 32'hFFFFFFFF);

    rst = 1'b1;
    we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0;
    issue_valid = 0; issue_wa = 0; flush = 0; clr = 0;
    #1;
    check("reset ready",    DW'(ready),    '0);
    check("reset rd1",      rd1,           '0);
    check("reset rd2",      rd2,           '0);
    check("reset rd1_busy", DW'(rd1_busy), '0);
    check("reset rd2_busy", DW'(rd2_busy), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Initial sweep: 32 cycles with ready low, then every entry reads 0
    sweep(DEPTH, idle, "init_sweep");
    for (int i = 0; i < DEPTH; i++)
      step(mk(0, 0, 0, AW'(i), AW'(DEPTH - 1 - i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
           $sformatf("read_all%0d", i));

    for (int i = 0; i < 19; i++) step(vt[i], $sformatf("vec%0d", i));

    // clr issued by vt[18]: writes and issues during the sweep must be ignored
    sweep(DEPTH, busy_stim, "clr_sweep");
    step(mk(0, 0, 0, 12, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "post_clr rf12");
    step(mk(0, 0, 0, 13, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "post_clr busy13");

    // Asynchronous reset in RUN clears busy and restarts the sweep
    step(mk(0, 0, 0, 20, 0, 1, 20, 0, 0, 0, 0, 0, 0, 1, 0), "pre_rst issue20");
    step(mk(0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "pre_rst busy20");
    #2 rst = 1'b1;
    #1;
    check("rst_run ready",    DW'(ready),    '0);
    check("rst_run rd1_busy", DW'(rd1_busy), '0);
    @(negedge clk);
    rst = 1'b0;
    sweep(DEPTH, idle, "rst_run_sweep");
    step(mk(0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "post_rst busy20");

    // Asynchronous reset at sweep cycle 10 restarts the full sweep
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "clr2 start");
    sweep(10, idle, "clr2_sweep");
    rst = 1'b1;
    #1;
    check("rst_sweep ready", DW'(ready), '0);
    @(negedge clk);
    rst = 1'b0;
    sweep(DEPTH, idle, "restart_sweep");
    step(mk(0, 0, 0, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "restart done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
